// File: rtl/vector_pack_ctrl.sv
// ============================================================================
// Module   : vector_pack_ctrl
// Purpose  : Packs NIB_NUM serial nibbles (first nibble in LSBs) into one word
//            behind a registered valid/ready output, with explicit flush.
//            Optional idle-timeout flush: define VECTOR_PACK_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_pack_ctrl #(
  parameter int NIB_W   = 4,
  parameter int NIB_NUM = 3,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = $clog2(NIB_NUM + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     nib_valid_in,
  input  logic [NIB_W-1:0]         nib_data_in,
  output logic                     nib_ready_out,
  input  logic                     flush_in,
  output logic                     word_valid_out,
  output logic [NIB_W*NIB_NUM-1:0] word_data_out,
  output logic [CNT_W-1:0]         word_cnt_out,
  input  logic                     word_ready_in,
  output logic                     busy_out
);

  localparam int               c_WORD_W = NIB_W * NIB_NUM;
  localparam logic [CNT_W-1:0] c_FULL   = CNT_W'(NIB_NUM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_WORD_W-1:0]   r_data;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_word_valid;
  logic [c_WORD_W-1:0]   r_word_data;
  logic [CNT_W-1:0]      r_word_cnt;

  logic                  w_nib_acc;
  logic                  w_slot_free;
  logic                  w_flush;
  logic                  w_tmo;
  logic [c_WORD_W-1:0]   w_data_nx;
  logic [CNT_W-1:0]      w_cnt_nx;
  logic                  w_complete;
  logic                  w_load;
  logic [c_WORD_W-1:0]   w_load_data;
  logic [CNT_W-1:0]      w_load_cnt;
  logic                  w_stay_fill;

  assign w_nib_acc   = nib_valid_in & (r_state != S_HOLD);
  assign w_slot_free = ~r_word_valid | word_ready_in;
  assign w_flush     = flush_in | w_tmo;
  assign w_cnt_nx    = r_cnt + {{(CNT_W-1){1'b0}}, w_nib_acc};

  // The collector is cleared whenever a word leaves it, so only the slot
  // addressed by the current count ever needs writing.
  always_comb begin
    w_data_nx = r_data;
    for (int k = 0; k < NIB_NUM; k++) begin
      if (w_nib_acc && (r_cnt == CNT_W'(k))) begin
        w_data_nx[k*NIB_W +: NIB_W] = nib_data_in;
      end
    end
  end

  // A flush with nothing collected (and nothing arriving) is not a word.
  assign w_complete  = (r_state != S_HOLD) &
                       ((w_cnt_nx == c_FULL) | (w_flush & (w_cnt_nx != '0)));
  assign w_load      = (r_state == S_HOLD) ? w_slot_free : (w_complete & w_slot_free);
  assign w_load_data = (r_state == S_HOLD) ? r_data : w_data_nx;
  assign w_load_cnt  = (r_state == S_HOLD) ? r_cnt  : w_cnt_nx;
  assign w_stay_fill = (r_state != S_HOLD) & ~w_complete & (w_cnt_nx != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_data       <= '0;
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_word_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_word_valid <= 1'b1;
        r_word_data  <= w_load_data;
        r_word_cnt   <= w_load_cnt;
      end else if (word_ready_in) begin
        r_word_valid <= 1'b0;
      end

      case (r_state)
        S_HOLD: begin
          if (w_slot_free) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
          end
        end
        default: begin
          if (w_complete && w_slot_free) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
          end else if (w_complete) begin
            r_state <= S_HOLD;
            r_data  <= w_data_nx;
            r_cnt   <= w_cnt_nx;
          end else begin
            r_state <= (w_cnt_nx == '0) ? S_IDLE : S_FILL;
            r_data  <= w_data_nx;
            r_cnt   <= w_cnt_nx;
          end
        end
      endcase
    end
  end

`ifdef VECTOR_PACK_TIMEOUT_EN
  localparam int              c_IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT - 1);

  logic [c_IDLE_W-1:0] r_idle;

  assign w_tmo = (r_state == S_FILL) & ~w_nib_acc & (r_idle == c_IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (w_stay_fill && !w_nib_acc) begin
      r_idle <= r_idle + 1'b1;
    end else begin
      r_idle <= '0;
    end
  end
`else
  logic w_timeout_unused;

  assign w_tmo            = 1'b0;
  assign w_timeout_unused = (TIMEOUT != 0) & w_stay_fill;
`endif

  assign nib_ready_out  = (r_state != S_HOLD);
  assign busy_out       = (r_state != S_IDLE) | r_word_valid;
  assign word_valid_out = r_word_valid;
  assign word_data_out  = r_word_data;
  assign word_cnt_out   = r_word_cnt;

endmodule

`default_nettype wire
